// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: opcodes, FSM states,
// default operand width and small opcode classification helpers.
package alu_pkg;

   localparam int ALU_WIDTH = 16;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_MUL  = 3'b010,
      OP_DIV  = 3'b011,
      OP_AND  = 3'b100,
      OP_OR   = 3'b101,
      OP_XOR  = 3'b110,
      OP_XNOR = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Opcodes that bypass the serial slice and report err.
   function automatic logic op_unsup(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   // Ops that produce a meaningful carry / overflow.
   function automatic logic op_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU slice used as the serial datapath.
// Ports: a, b, cin (bit inputs), op (3-bit opcode) -> r (result bit),
// co (carry out; 0 for logic and unsupported ops).
module alu_1bit
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic [2:0] op,
   output logic       r,
   output logic       co
);

   logic bx;

   always_comb begin
      r  = 1'b0;
      co = 1'b0;
      // SUB is A + ~B + 1; the +1 arrives as the initial carry.
      bx = (op == OP_SUB) ? ~b : b;
      unique case (1'b1)
         (op == OP_ADD),
         (op == OP_SUB): begin
            r  = a ^ bx ^ cin;
            co = (a & bx) | (a & cin) | (bx & cin);
         end
         (op == OP_AND):  r = a & b;
         (op == OP_OR):   r = a | b;
         (op == OP_XOR):  r = a ^ b;
         (op == OP_XNOR): r = ~(a ^ b);
         default: begin
            r  = 1'b0;
            co = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU controller: accepts one request at a time, processes
// operands LSB first through a single alu_1bit slice, then holds the
// result until the consumer takes it.
// Ports: clk, rst_n (async, active-low); request in_valid/in_ready with
// op_a, op_b, op_sel; response out_valid/out_ready with result, cout,
// err. Optional flags zero/ovf exist only when ALU_SEQ_FLAGS_EN is
// defined.
module alu_serial_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [2:0]       op_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
`ifdef ALU_SEQ_FLAGS_EN
   output logic             zero,
   output logic             ovf,
`endif
   output logic             err
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state;
   state_e           state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] res;
   logic [2:0]       rop;
   logic             carry;
   logic             cout_q;
   logic             err_q;
   logic             s_r;
   logic             s_co;
   logic             last;
   logic             accept;

   assign last   = (cnt == LAST);
   assign accept = in_valid && (state == ST_IDLE);

   alu_1bit u_slice (
      .a   (ra[cnt]),
      .b   (rb[cnt]),
      .cin (carry),
      .op  (rop),
      .r   (s_r),
      .co  (s_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = op_unsup(op_sel) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (last) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra     <= '0;
         rb     <= '0;
         rop    <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         res    <= '0;
         cout_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (accept) begin
         ra     <= op_a;
         rb     <= op_b;
         rop    <= op_sel;
         cnt    <= '0;
         carry  <= (op_sel == OP_SUB);
         res    <= '0;
         cout_q <= 1'b0;
         err_q  <= op_unsup(op_sel);
      end else if (state == ST_RUN) begin
         res[cnt] <= s_r;
         carry    <= s_co;
         if (last) begin
            cout_q <= op_arith(rop) ? s_co : 1'b0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign result = res;
   assign cout   = cout_q;
   assign err    = err_q;

`ifdef ALU_SEQ_FLAGS_EN
   logic ovf_q;

   // Signed overflow: carry into the MSB differs from carry out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (accept) begin
         ovf_q <= 1'b0;
      end else if (state == ST_RUN && last) begin
         ovf_q <= op_arith(rop) ? (carry ^ s_co) : 1'b0;
      end
   end

   assign ovf  = ovf_q;
   assign zero = out_valid && (res == '0);
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq: directed and random requests
// compared against an arithmetic reference model.
module tb_alu_serial_seq;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic [2:0]   op_sel = 3'd0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         cout;
   logic         err;
`ifdef ALU_SEQ_FLAGS_EN
   logic         zero;
   logic         ovf;
`endif

   int nvec = 0;
   int nerr = 0;

   alu_serial_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_sel    (op_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
`ifdef ALU_SEQ_FLAGS_EN
      .zero      (zero),
      .ovf       (ovf),
`endif
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic [2:0] op,
                                 output logic [W-1:0] r,
                                 output logic c, output logic e,
                                 output logic v);
      logic [W:0] s;
      r = '0; c = 1'b0; e = 1'b0; v = 1'b0;
      case (op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0];
            c = s[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'd1: begin
            r = a - b;
            c = (a >= b);
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'd2, 3'd3: e = 1'b1;
         3'd4: r = a & b;
         3'd5: r = a | b;
         3'd6: r = a ^ b;
         default: r = ~(a ^ b);
      endcase
   endfunction

   task automatic check_out(input logic [W-1:0] er, input logic ec,
                            input logic ee, input logic ev);
      chk("result", result, er);
      chk("cout", cout, ec);
      chk("err", err, ee);
      chk("out_valid", out_valid, 1'b1);
      chk("in_ready_busy", in_ready, 1'b0);
`ifdef ALU_SEQ_FLAGS_EN
      chk("zero", zero, er == '0);
      chk("ovf", ovf, ev);
`else
      if (ev === 1'bx) $display("unexpected x flag");
`endif
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input int hold);
      logic [W-1:0] er;
      logic ec, ee, ev;
      int lat;
      model(a, b, op, er, ec, ee, ev);
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1'b1);
      in_valid = 1'b1;
      op_a = a;
      op_b = b;
      op_sel = op;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      // Garbage on the request side must be ignored while busy.
      in_valid = 1'($urandom);
      op_a = W'($urandom);
      op_b = W'($urandom);
      op_sel = 3'($urandom);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      in_valid = 1'b0;
      chk("latency", lat, ee ? 0 : W);
      check_out(er, ec, ee, ev);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check_out(er, ec, ee, ev);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("handoff_valid", out_valid, 1'b0);
      chk("handoff_ready", in_ready, 1'b1);
   endtask

   initial begin
      #2;
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_result", result, '0);
      chk("rst_cout", cout, 1'b0);
      chk("rst_err", err, 1'b0);
      #10 rst_n = 1'b1;

      do_op(16'h00FF, 16'h0001, 3'd0, 0);
      do_op(16'hFFFF, 16'h0001, 3'd0, 1);
      do_op(16'h0005, 16'h0007, 3'd1, 0);
      do_op(16'h8000, 16'h0001, 3'd1, 2);
      do_op(16'hA5A5, 16'hFFFF, 3'd6, 0);
      do_op(16'h1234, 16'h1234, 3'd7, 0);
      do_op(16'h0003, 16'h0004, 3'd2, 5);
      do_op(16'h0009, 16'h0002, 3'd3, 1);
      do_op(16'h7FFF, 16'h0001, 3'd0, 0);
      do_op(16'h1234, 16'h1234, 3'd1, 0);

      // Reset in the middle of an ADD discards it.
      @(negedge clk);
      in_valid = 1'b1;
      op_a = 16'h1111;
      op_b = 16'h2222;
      op_sel = 3'd0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_ready", in_ready, 1'b1);
      chk("midrst_result", result, '0);
      chk("midrst_cout", cout, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(16'h0002, 16'h0003, 3'd0, 0);

      for (int k = 0; k < 40; k++) begin
         do_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
